// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: opcode map, ALU code mapping, sequencer modes and the control word
// shared by the control sequencer and its decoder.
package cpu_defs_pkg;

    localparam int OPW   = 5;
    localparam int STEPW = 3;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_BR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_IN   = 5'b10110;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPW-1:0] OP_MFHI = 5'b11001;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_INCPC = 5'b11111;

    typedef enum logic [1:0] {MODE_RST, MODE_EXEC, MODE_HALT} mode_t;

    typedef struct packed {
        logic       pc_out;
        logic       zhi_out;
        logic       zlo_out;
        logic       hi_out;
        logic       lo_out;
        logic       mdr_out;
        logic       iport_out;
        logic       c_out;
        logic       pc_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       mdr_in;
        logic       mar_in;
        logic       y_in;
        logic       oport_in;
        logic       ir_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       con_in;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] alu_code;
    } ctrl_t;

    // Immediates, address arithmetic and branch targets all reuse the register-form ALU op.
    function automatic logic [4:0] alu_of(input logic [OPW-1:0] op);
        case (op)
            OP_ADDI, OP_LD, OP_LDI, OP_ST, OP_BR: return OP_ADD;
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return op;
        endcase
    endfunction

    // Final step of each instruction; opcodes without execute steps end at T2.
    function automatic logic [STEPW-1:0] last_of(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:          return 3'd5;
            OP_NEG, OP_NOT:                            return 3'd4;
            OP_MUL, OP_DIV, OP_BR:                     return 3'd6;
            OP_LD, OP_ST:                              return 3'd7;
            OP_JR, OP_MFHI, OP_MFLO, OP_IN, OP_OUT:    return 3'd3;
            default:                                   return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational map from sequencer state, opcode and branch flag
// to the DataPath control word and the end-of-instruction flag.
module seq_decode
    import cpu_defs_pkg::*;
(
    input  mode_t            mode,
    input  logic [STEPW-1:0] step,
    input  logic [OPW-1:0]   opcode,
    input  logic             con,
    output ctrl_t            ctrl,
    output logic             last_step
);

    logic s3, s4, s5, s6, s7, imm, ldi, ld, st;

    assign s3  = step == 3'd3;
    assign s4  = step == 3'd4;
    assign s5  = step == 3'd5;
    assign s6  = step == 3'd6;
    assign s7  = step == 3'd7;
    assign imm = opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
    assign ldi = opcode == OP_LDI;
    assign ld  = opcode == OP_LD;
    assign st  = opcode == OP_ST;

    always_comb begin
        ctrl = '0;
        last_step = 1'b0;
        if (mode == MODE_EXEC) begin
            last_step = step == last_of(opcode);
            case (step)
                3'd0: begin
                    ctrl.pc_out = 1'b1;
                    ctrl.mar_in = 1'b1;
                    ctrl.z_in = 1'b1;
                    ctrl.alu_code = ALU_INCPC;
                end
                3'd1: begin
                    ctrl.zlo_out = 1'b1;
                    ctrl.pc_in = 1'b1;
                    ctrl.mem_read = 1'b1;
                    ctrl.mdr_in = 1'b1;
                end
                3'd2: begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.ir_in = 1'b1;
                end
                default: case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        ctrl.grb = s3;
                        ctrl.y_in = s3;
                        ctrl.grc = s4 && !imm;
                        ctrl.c_out = s4 && imm;
                        ctrl.r_out = s3 || (s4 && !imm);
                        ctrl.z_in = s4;
                        ctrl.alu_code = s4 ? alu_of(opcode) : '0;
                        ctrl.zlo_out = s5;
                        ctrl.gra = s5;
                        ctrl.r_in = s5;
                    end
                    OP_NEG, OP_NOT: begin
                        ctrl.grb = s3;
                        ctrl.r_out = s3;
                        ctrl.z_in = s3;
                        ctrl.alu_code = s3 ? opcode : '0;
                        ctrl.zlo_out = s4;
                        ctrl.gra = s4;
                        ctrl.r_in = s4;
                    end
                    OP_MUL, OP_DIV: begin
                        ctrl.gra = s3;
                        ctrl.y_in = s3;
                        ctrl.r_out = s3 || s4;
                        ctrl.grb = s4;
                        ctrl.z_in = s4;
                        ctrl.alu_code = s4 ? opcode : '0;
                        ctrl.zlo_out = s5;
                        ctrl.lo_in = s5;
                        ctrl.zhi_out = s6;
                        ctrl.hi_in = s6;
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        ctrl.grb = s3;
                        ctrl.ba_out = s3;
                        ctrl.y_in = s3;
                        ctrl.c_out = s4;
                        ctrl.z_in = s4;
                        ctrl.alu_code = s4 ? alu_of(opcode) : '0;
                        ctrl.zlo_out = s5;
                        ctrl.mar_in = s5 && !ldi;
                        ctrl.gra = ldi ? s5 : ld ? s7 : s6;
                        ctrl.r_in = ldi ? s5 : ld && s7;
                        ctrl.mdr_in = s6 && !ldi;
                        ctrl.mem_read = s6 && ld;
                        ctrl.mdr_out = s7 && ld;
                        ctrl.r_out = s6 && st;
                        ctrl.mem_write = s7 && st;
                    end
                    OP_BR: begin
                        ctrl.gra = s3;
                        ctrl.r_out = s3;
                        ctrl.con_in = s3;
                        ctrl.pc_out = s4;
                        ctrl.y_in = s4;
                        ctrl.c_out = s5;
                        ctrl.z_in = s5;
                        ctrl.alu_code = s5 ? alu_of(opcode) : '0;
                        ctrl.zlo_out = s6;
                        ctrl.pc_in = s6 && con;
                    end
                    OP_JR: begin
                        ctrl.gra = s3;
                        ctrl.r_out = s3;
                        ctrl.pc_in = s3;
                    end
                    OP_MFHI, OP_MFLO, OP_IN: begin
                        ctrl.gra = s3;
                        ctrl.r_in = s3;
                        ctrl.hi_out = s3 && opcode == OP_MFHI;
                        ctrl.lo_out = s3 && opcode == OP_MFLO;
                        ctrl.iport_out = s3 && opcode == OP_IN;
                    end
                    OP_OUT: begin
                        ctrl.gra = s3;
                        ctrl.r_out = s3;
                        ctrl.oport_in = s3;
                    end
                    default: ;
                endcase
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore sequencer for the RISC DataPath; holds {mode, step}
// and drives the control lines decoded from state and IR.
module control_sequencer
    import cpu_defs_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        ConOut,
    output logic        PCOut,
    output logic        ZHiOut,
    output logic        ZLoOut,
    output logic        HiOut,
    output logic        LoOut,
    output logic        MDROut,
    output logic        IPortOut,
    output logic        COut,
    output logic        PCIn,
    output logic        ZIn,
    output logic        HiIn,
    output logic        LoIn,
    output logic        MDRIn,
    output logic        MARIn,
    output logic        YIn,
    output logic        OPortIn,
    output logic        IRIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        RIn,
    output logic        ROut,
    output logic        BAOut,
    output logic        Conin,
    output logic        memread,
    output logic        memwrite,
    output logic [4:0]  ALUCode,
    output logic        run
);

    mode_t            mode;
    logic [STEPW-1:0] step;
    logic [OPW-1:0]   opcode;
    ctrl_t            ctrl;
    logic             last_step;
    logic             unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    seq_decode u_decode (
        .mode      (mode),
        .step      (step),
        .opcode    (opcode),
        .con       (ConOut),
        .ctrl      (ctrl),
        .last_step (last_step)
    );

    // Outputs decode straight from the async-reset state so clear blanks them immediately.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mode <= MODE_RST;
            step <= '0;
        end else if (mode == MODE_RST) begin
            mode <= MODE_EXEC;
            step <= '0;
        end else if (mode == MODE_EXEC) begin
            step <= last_step ? '0 : step + 1'b1;
            if (last_step && opcode == OP_HALT)
                mode <= MODE_HALT;
        end
    end

    assign {PCOut, ZHiOut, ZLoOut, HiOut, LoOut, MDROut, IPortOut, COut} =
        {ctrl.pc_out, ctrl.zhi_out, ctrl.zlo_out, ctrl.hi_out, ctrl.lo_out,
         ctrl.mdr_out, ctrl.iport_out, ctrl.c_out};
    assign {PCIn, ZIn, HiIn, LoIn, MDRIn, MARIn, YIn, OPortIn, IRIn} =
        {ctrl.pc_in, ctrl.z_in, ctrl.hi_in, ctrl.lo_in, ctrl.mdr_in,
         ctrl.mar_in, ctrl.y_in, ctrl.oport_in, ctrl.ir_in};
    assign {Gra, Grb, Grc, RIn, ROut, BAOut, Conin} =
        {ctrl.gra, ctrl.grb, ctrl.grc, ctrl.r_in, ctrl.r_out, ctrl.ba_out, ctrl.con_in};
    assign {memread, memwrite} = {ctrl.mem_read, ctrl.mem_write};
    assign ALUCode = ctrl.alu_code;
    assign run     = mode == MODE_EXEC;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction streams checked step by step against
// a per-instruction table of expected control words.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        ConOut;
    logic PCOut, ZHiOut, ZLoOut, HiOut, LoOut, MDROut, IPortOut, COut;
    logic PCIn, ZIn, HiIn, LoIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, run;
    logic [4:0]  ALUCode;
    logic [31:0] obs;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [4:0] O_LD = 0, O_LDI = 1, O_ST = 2, O_ADD = 3, O_SUB = 4, O_AND = 5,
        O_OR = 6, O_ROR = 7, O_ROL = 8, O_SHR = 9, O_SHL = 11, O_ADDI = 12, O_ANDI = 13,
        O_ORI = 14, O_DIV = 15, O_MUL = 16, O_NEG = 17, O_NOT = 18, O_BR = 19, O_JR = 20,
        O_IN = 22, O_OUT = 23, O_MFLO = 24, O_MFHI = 25, O_NOP = 26, O_HALT = 27;

    localparam logic [31:0] MEMW = 32'd1 << 0, MEMR = 32'd1 << 1, CONIN = 32'd1 << 2,
        BAOUT = 32'd1 << 3, ROUT = 32'd1 << 4, RIN = 32'd1 << 5, GRC = 32'd1 << 6,
        GRB = 32'd1 << 7, GRA = 32'd1 << 8, IRIN = 32'd1 << 9, OPORTIN = 32'd1 << 10,
        YIN = 32'd1 << 11, MARIN = 32'd1 << 12, MDRIN = 32'd1 << 13, LOIN = 32'd1 << 14,
        HIIN = 32'd1 << 15, ZIN = 32'd1 << 16, PCIN = 32'd1 << 17, COUT = 32'd1 << 18,
        IPORTOUT = 32'd1 << 19, MDROUT = 32'd1 << 20, LOOUT = 32'd1 << 21,
        HIOUT = 32'd1 << 22, ZLOOUT = 32'd1 << 23, ZHIOUT = 32'd1 << 24,
        PCOUT = 32'd1 << 25, RUN = 32'd1 << 31;
    localparam logic [31:0] BUS = PCOUT | ZHIOUT | ZLOOUT | HIOUT | LOOUT | MDROUT |
        IPORTOUT | COUT | ROUT | BAOUT;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .ConOut(ConOut),
        .PCOut(PCOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut), .HiOut(HiOut), .LoOut(LoOut),
        .MDROut(MDROut), .IPortOut(IPortOut), .COut(COut),
        .PCIn(PCIn), .ZIn(ZIn), .HiIn(HiIn), .LoIn(LoIn), .MDRIn(MDRIn), .MARIn(MARIn),
        .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut), .BAOut(BAOut),
        .Conin(Conin), .memread(memread), .memwrite(memwrite),
        .ALUCode(ALUCode), .run(run)
    );

    assign obs = {run, ALUCode, PCOut, ZHiOut, ZLoOut, HiOut, LoOut, MDROut, IPortOut, COut,
                  PCIn, ZIn, HiIn, LoIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
                  Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite};

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] alu(input logic [4:0] c);
        return {1'b0, c, 26'b0};
    endfunction

    // Expected control word for every step of one instruction, fetch included.
    function automatic void build(input logic [4:0] op, input logic con);
        logic [4:0] ac;
        logic       imm;
        exp_q = {};
        exp_q.push_back(PCOUT | MARIN | ZIN | alu(5'h1f));
        exp_q.push_back(ZLOOUT | PCIN | MEMR | MDRIN);
        exp_q.push_back(MDROUT | IRIN);
        imm = op == O_ADDI || op == O_ANDI || op == O_ORI;
        ac  = op == O_ADDI ? O_ADD : op == O_ANDI ? O_AND : op == O_ORI ? O_OR : op;
        case (op)
            O_ADD, O_SUB, O_AND, O_OR, O_SHR, O_SHL, O_ROR, O_ROL, O_ADDI, O_ANDI, O_ORI: begin
                exp_q.push_back(GRB | ROUT | YIN);
                exp_q.push_back((imm ? COUT : GRC | ROUT) | alu(ac) | ZIN);
                exp_q.push_back(ZLOOUT | GRA | RIN);
            end
            O_NEG, O_NOT: begin
                exp_q.push_back(GRB | ROUT | alu(op) | ZIN);
                exp_q.push_back(ZLOOUT | GRA | RIN);
            end
            O_MUL, O_DIV: begin
                exp_q.push_back(GRA | ROUT | YIN);
                exp_q.push_back(GRB | ROUT | alu(op) | ZIN);
                exp_q.push_back(ZLOOUT | LOIN);
                exp_q.push_back(ZHIOUT | HIIN);
            end
            O_LD, O_LDI, O_ST: begin
                exp_q.push_back(GRB | BAOUT | YIN);
                exp_q.push_back(COUT | alu(O_ADD) | ZIN);
                if (op == O_LDI) exp_q.push_back(ZLOOUT | GRA | RIN);
                else begin
                    exp_q.push_back(ZLOOUT | MARIN);
                    exp_q.push_back(op == O_LD ? MEMR | MDRIN : GRA | ROUT | MDRIN);
                    exp_q.push_back(op == O_LD ? MDROUT | GRA | RIN : MEMW);
                end
            end
            O_BR: begin
                exp_q.push_back(GRA | ROUT | CONIN);
                exp_q.push_back(PCOUT | YIN);
                exp_q.push_back(COUT | alu(O_ADD) | ZIN);
                exp_q.push_back(ZLOOUT | (con ? PCIN : 32'd0));
            end
            O_JR:   exp_q.push_back(GRA | ROUT | PCIN);
            O_MFHI: exp_q.push_back(GRA | RIN | HIOUT);
            O_MFLO: exp_q.push_back(GRA | RIN | LOOUT);
            O_IN:   exp_q.push_back(IPORTOUT | GRA | RIN);
            O_OUT:  exp_q.push_back(GRA | ROUT | OPORTIN);
            default: ;
        endcase
    endfunction

    // IR changes only once the sequencer is in T0, where the control word ignores it.
    task automatic run_instr(input logic [4:0] op, input logic con, input int stop);
        build(op, con);
        foreach (exp_q[i]) begin
            @(posedge clock);
            #1;
            if (i == 0) begin
                IR = {op, 27'($urandom)};
                ConOut = con;
            end
            check($sformatf("op%0d_t%0d", op, i), obs, RUN | exp_q[i]);
            check("bus_src", {31'b0, $countones(obs & BUS) <= 1}, 32'd1);
            if (i == stop) begin
                clear = 1'b1;
                #1;
                check("clear_async", obs, 32'd0);
                @(posedge clock);
                #1 clear = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        logic [4:0] op;
        clear = 1'b1;
        IR = 32'd0;
        ConOut = 1'b0;
        repeat (2) @(posedge clock);
        #1 check("reset", obs, 32'd0);
        clear = 1'b0;
        #1 check("reset_hold", obs, 32'd0);
        run_instr(O_MFLO, 1'b0, -1);
        run_instr(O_ADD, 1'b0, -1);
        run_instr(O_BR, 1'b0, -1);
        run_instr(O_BR, 1'b1, -1);
        run_instr(O_ST, 1'b1, -1);
        run_instr(O_NOP, 1'b0, -1);
        repeat (250) begin
            op = 5'($urandom_range(0, 31));
            if (op == O_HALT) op = O_NOP;
            run_instr(op, 1'($urandom), -1);
        end
        run_instr(O_LD, 1'b0, 5);
        run_instr(O_MFLO, 1'b0, -1);
        run_instr(O_HALT, 1'b0, -1);
        repeat (20) begin
            @(posedge clock);
            #1 check("halt", obs, 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
